// File: rtl/shift_seq_ctrl.sv
// Sequencer for an external N-bit shift register: accepts a word/direction/length
// command, issues one load strobe, the requested number of shift strobes, then a done pulse.
module shift_seq_ctrl #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [N-1:0]  cmd_data,
  input  logic          cmd_dir,
  input  logic [CW-1:0] cmd_len,
  input  logic          stall,
  input  logic          abort,
  output logic          sr_clr,
  output logic          sr_load,
  output logic          sr_left,
  output logic          sr_right,
  output logic [N-1:0]  sr_pdata,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] remaining,
  output logic [2:0]    state_dbg
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] CLEAR = 3'd4;

  localparam logic [CW-1:0] FULL_LEN = CW'(N);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic          dir_q;
  logic [CW-1:0] len_norm;
  logic          accept;
  logic          shift_go;
  logic          abortable;

  // Handshake: a command transfers on any rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready depends only on state, never on cmd_valid.
  assign accept    = cmd_valid & cmd_ready;
  assign shift_go  = (state == SHIFT) & ~stall;
  assign abortable = (state == LOAD) | (state == SHIFT) | (state == DONE);

  // Zero or out-of-range lengths mean a full-width shift.
  always_comb begin
    len_norm = cmd_len;
    if ((cmd_len == '0) || (cmd_len > FULL_LEN)) len_norm = FULL_LEN;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOAD;
      LOAD:    state_nxt = abort ? CLEAR : SHIFT;
      SHIFT: begin
        if (abort)                                   state_nxt = CLEAR;
        else if (!stall && (remaining <= CW'(1)))    state_nxt = DONE;
      end
      DONE:    state_nxt = abort ? CLEAR : IDLE;
      CLEAR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sr_pdata  <= '0;
      dir_q     <= 1'b0;
      remaining <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sr_pdata  <= cmd_data;
        dir_q     <= cmd_dir;
        remaining <= len_norm;
      end else if (abort && abortable) begin
        remaining <= '0;
      end else if (shift_go && (remaining != '0)) begin
        remaining <= remaining - CW'(1);
      end
    end
  end

  // Strobes come from registered state; only stall gates the shift strobe.
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign sr_clr    = (state == CLEAR);
  assign sr_load   = (state == LOAD);
  assign sr_left   = shift_go & ~dir_q;
  assign sr_right  = shift_go & dir_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: table vectors, hand-built corner sequences and random
// commands, checked every cycle against a schedule built from the command rules.
module tb_shift_seq_ctrl;

  localparam int N  = 4;
  localparam int CW = 3;
  localparam int W  = N + CW + 7;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [N-1:0]  cmd_data;
  logic          cmd_dir;
  logic [CW-1:0] cmd_len;
  logic          stall;
  logic          abort;
  logic          sr_clr;
  logic          sr_load;
  logic          sr_left;
  logic          sr_right;
  logic [N-1:0]  sr_pdata;
  logic          busy;
  logic          done;
  logic [CW-1:0] remaining;
  logic [2:0]    state_dbg;

  shift_seq_ctrl #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_dir(cmd_dir), .cmd_len(cmd_len), .stall(stall), .abort(abort),
    .sr_clr(sr_clr), .sr_load(sr_load), .sr_left(sr_left), .sr_right(sr_right),
    .sr_pdata(sr_pdata), .busy(busy), .done(done), .remaining(remaining),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External shift register driven by the controller's strobes, serial-in = 0.
  logic [N-1:0] sr_model;
  always @(posedge clk) begin
    if (sr_clr)        sr_model <= '0;
    else if (sr_load)  sr_model <= sr_pdata;
    else if (sr_left)  sr_model <= sr_model << 1;
    else if (sr_right) sr_model <= sr_model >> 1;
  end

  // ---------------- scoreboard ----------------
  int           checks = 0;
  int           errors = 0;
  int           cmd_id = 0;
  logic [W-1:0] exp_q[$];
  logic [N-1:0] m_pdata;

  function automatic logic [W-1:0] rec(input logic clr, input logic ld, input logic lft,
                                       input logic rgt, input logic bsy, input logic dn,
                                       input logic rdy, input int rem, input logic [N-1:0] pd);
    return {clr, ld, lft, rgt, bsy, dn, rdy, CW'(rem), pd};
  endfunction

  function automatic logic [W-1:0] actual();
    return {sr_clr, sr_load, sr_left, sr_right, busy, done, cmd_ready, remaining, sr_pdata};
  endfunction

  task automatic check_rec(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: clr,ld,l,r,busy,done,rdy,rem,pdata got %b expected %b (state_dbg %0d)",
               name, got, exp, state_dbg);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_excl(input string name);
    checks++;
    if ($countones({sr_clr, sr_load, sr_left, sr_right}) > 1) begin
      errors++;
      $display("FAIL %s strobe exclusivity: got clr/ld/l/r %b expected at most one high",
               name, {sr_clr, sr_load, sr_left, sr_right});
    end
  endtask

  function automatic int norm_len(input int len);
    return ((len == 0) || (len > N)) ? N : len;
  endfunction

  // ---------------- driver + reference schedule ----------------
  // Offset 0 is the accept cycle; mask bit k is the stall input at offset k;
  // abort_at (nonzero) drives abort at that offset.
  task automatic run_cmd(input logic [N-1:0] data, input logic dir, input int len,
                         input logic [31:0] mask, input int abort_at,
                         input logic idle_abort, input logic chain);
    int L;
    int rem;
    int off;
    int n;
    logic st;
    logic aborted;
    logic [N-1:0] exp_sr;
    logic [N-1:0] tmp;
    L = norm_len(len);
    cmd_id++;
    exp_q.delete();
    aborted = 1'b0;
    exp_q.push_back(rec(0, 0, 0, 0, 0, 0, 1, 0, m_pdata));
    exp_q.push_back(rec(0, 1, 0, 0, 1, 0, 0, L, data));
    if (abort_at == 1) begin
      exp_q.push_back(rec(1, 0, 0, 0, 1, 0, 0, 0, data));
      aborted = 1'b1;
    end else begin
      rem = L;
      off = 2;
      while (1) begin
        st = (off < 32) ? mask[off] : 1'b0;
        if (off == abort_at) begin
          exp_q.push_back(rec(0, 0, ~st & ~dir, ~st & dir, 1, 0, 0, rem, data));
          exp_q.push_back(rec(1, 0, 0, 0, 1, 0, 0, 0, data));
          aborted = 1'b1;
          break;
        end
        exp_q.push_back(rec(0, 0, ~st & ~dir, ~st & dir, 1, 0, 0, rem, data));
        off++;
        if (!st) begin
          rem--;
          if (rem == 0) begin
            exp_q.push_back(rec(0, 0, 0, 0, 1, 1, 0, 0, data));
            if (off == abort_at) begin
              exp_q.push_back(rec(1, 0, 0, 0, 1, 0, 0, 0, data));
              aborted = 1'b1;
            end
            break;
          end
        end
      end
    end

    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cmd_valid = (k == 0 || chain) ? 1'b1 : 1'(($urandom_range(0, 1)));
      cmd_data  = (k == 0) ? data : N'($urandom_range(0, 2**N - 1));
      cmd_dir   = (k == 0) ? dir : 1'($urandom_range(0, 1));
      cmd_len   = (k == 0) ? CW'(len) : CW'($urandom_range(0, 2**CW - 1));
      stall     = (k < 32) ? mask[k] : 1'b0;
      abort     = ((abort_at != 0) && (k == abort_at)) || ((k == 0) && idle_abort);
      #1;
      check_excl($sformatf("cmd%0d off%0d", cmd_id, k));
      check_rec($sformatf("cmd%0d off%0d", cmd_id, k), actual(), exp_q.pop_front());
    end
    m_pdata = data;

    tmp    = data;
    exp_sr = aborted ? '0 : (dir ? (tmp >> L) : (tmp << L));
    @(posedge clk);
    #1;
    check_val($sformatf("cmd%0d final sr", cmd_id), int'(sr_model), int'(exp_sr));

    if (!chain) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      stall     = 1'b0;
      abort     = 1'b0;
      #1;
      check_rec($sformatf("cmd%0d idle after", cmd_id), actual(),
                rec(0, 0, 0, 0, 0, 0, 1, 0, data));
    end
  endtask

  // ---------------- test vectors ----------------
  typedef struct {
    logic [N-1:0] data;
    logic         dir;
    int           len;
    logic [31:0]  mask;
    int           abort_at;
    logic         idle_abort;
    logic [N-1:0] exp_sr;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{4'b1011, 1'b0, 4, 32'h0,                 0, 1'b0, 4'b0000};
    tbl[1] = '{4'b1011, 1'b1, 2, 32'h1 << 3,            0, 1'b0, 4'b0010};
    tbl[2] = '{4'b0110, 1'b0, 0, 32'h0,                 0, 1'b0, 4'b0000};
    tbl[3] = '{4'b1111, 1'b1, 7, 32'h0,                 0, 1'b0, 4'b0000};
    tbl[4] = '{4'b1001, 1'b0, 1, 32'h0,                 0, 1'b0, 4'b0010};
    tbl[5] = '{4'b1101, 1'b0, 4, 32'h0,                 4, 1'b0, 4'b0000};
    tbl[6] = '{4'b0101, 1'b1, 1, (32'h1 << 2) | (32'h1 << 3), 0, 1'b1, 4'b0010};
    tbl[7] = '{4'b1110, 1'b1, 3, 32'h0,                 5, 1'b0, 4'b0000};
    tbl[8] = '{4'b0011, 1'b0, 2, 32'h0,                 1, 1'b0, 4'b0000};

    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    cmd_dir   = 1'b0;
    cmd_len   = '0;
    stall     = 1'b0;
    abort     = 1'b0;
    m_pdata   = '0;

    // reset values right after release, before any active edge
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_rec("reset state", actual(), rec(0, 0, 0, 0, 0, 0, 1, 0, 0));

    foreach (tbl[i]) begin
      run_cmd(tbl[i].data, tbl[i].dir, tbl[i].len, tbl[i].mask, tbl[i].abort_at,
              tbl[i].idle_abort, 1'b0);
      check_val($sformatf("table%0d sr", i), int'(sr_model), int'(tbl[i].exp_sr));
    end

    // back-to-back with cmd_valid held high across the first command
    run_cmd(4'b1100, 1'b0, 2, 32'h0, 0, 1'b0, 1'b1);
    run_cmd(4'b0111, 1'b1, 3, 32'h1 << 3, 0, 1'b0, 1'b0);

    // asynchronous reset while remaining == 2
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = 4'b1011; cmd_dir = 1'b0; cmd_len = 3'd4;
    stall = 1'b0; abort = 1'b0;
    repeat (4) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    #1;
    check_val("pre-reset remaining", int'(remaining), 2);
    check_val("pre-reset sr_left", int'(sr_left), 1);
    #1;
    rst = 1'b0;
    #1;
    check_rec("async reset mid-op",
              {sr_clr, sr_load, sr_left, sr_right, busy, done, 1'b1, remaining, sr_pdata},
              rec(0, 0, 0, 0, 0, 0, 1, 0, 0));
    @(negedge clk);
    rst = 1'b1;
    m_pdata = '0;
    #1;
    check_val("ready after release", int'(cmd_ready), 1);
    run_cmd(4'b1001, 1'b1, 4, 32'h1 << 4, 0, 1'b0, 1'b0);

    // randomized commands
    for (int r = 0; r < 40; r++) begin
      run_cmd(N'($urandom_range(0, 2**N - 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 2**CW - 1), $urandom & $urandom,
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    cmd_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
